fighter_anim_sequencer: RTL and testbench

// Sequences the animation of one fighter sprite: selects the character state (stand/attack/move/hurt/defend)

---
 rtl/fighter_anim_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_fighter_anim_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fighter_anim_sequencer.sv
// fighter_anim_sequencer
// Chooses the fighter's animation state (stand/attack/move/hurt/defend) from
// player requests and hit events. It also steps the frame index that the sprite
// address generators use. frame_clk is brought into the Clk domain through a
// two-flop synchronizer. Every TICKS_PER_FRAME rising edges of frame_clk make
// one animation step. State and frame change only on a step.
// Optional feature macro: HURT_IFRAME_EN. When it is defined, the fighter
// ignores hits during hurt and for IFRAME_TICKS ticks after hurt ends.
module fighter_anim_sequencer #(
    parameter int TICKS_PER_FRAME  = 4,
    parameter int STAND_FRAMES     = 8,
    parameter int MOVE_FRAMES      = 5,
    parameter int ATTACK_FRAMES    = 9,
    parameter int HURT_FRAMES      = 4,
    parameter int DEFEND_FRAMES    = 1,
    parameter int ATTACK_HIT_FRAME = 4
`ifdef HURT_IFRAME_EN
    ,
    parameter int IFRAME_TICKS     = 30
`endif
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       move_l,
    input  logic       move_r,
    input  logic       defend,
    input  logic       attack,
    input  logic       hit,
    output logic [7:0] char_state,
    output logic [7:0] frame_num,
    output logic       frame_adv,
    output logic       hit_window,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_STAND  = 3'd0,
        ST_ATTACK = 3'd1,
        ST_MOVE_L = 3'd2,
        ST_MOVE_R = 3'd3,
        ST_HURT   = 3'd4,
        ST_DEFEND = 3'd5
    } state_t;

    // Last frame index in each state's sprite strip
    function automatic logic [7:0] last_frame(input state_t s);
        logic [7:0] r;
        case (s)
            ST_ATTACK: r = 8'(ATTACK_FRAMES - 1);
            ST_MOVE_L: r = 8'(MOVE_FRAMES - 1);
            ST_MOVE_R: r = 8'(MOVE_FRAMES - 1);
            ST_HURT:   r = 8'(HURT_FRAMES - 1);
            ST_DEFEND: r = 8'(DEFEND_FRAMES - 1);
            default:   r = 8'(STAND_FRAMES - 1);
        endcase
        return r;
    endfunction

    logic       fclk_meta_q, fclk_meta_d;
    logic       fclk_sync_q, fclk_sync_d;
    logic       fclk_prev_q, fclk_prev_d;
    logic       tick_q, tick_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic       pend_atk_q, pend_atk_d;
    logic       pend_hit_q, pend_hit_d;
    state_t     state_q, state_d;
    logic [7:0] frame_q, frame_d;
    logic       frame_adv_q, frame_adv_d;

    logic       step;
    logic       hit_ignore;
    logic       atk_eff;
    logic       hit_eff;
    state_t     loop_next;

`ifdef HURT_IFRAME_EN
    localparam int IFW = $clog2(IFRAME_TICKS + 1);
    logic [IFW-1:0] iframe_cnt_q, iframe_cnt_d;
    assign hit_ignore = (state_q == ST_HURT) || (iframe_cnt_q != '0);
`else
    assign hit_ignore = 1'b0;
`endif

    // Next-state logic: synchronizer, tick counter, pending requests and the step decision
    always_comb begin
        fclk_meta_d = frame_clk;
        fclk_sync_d = fclk_meta_q;
        fclk_prev_d = fclk_sync_q;
        tick_d      = fclk_sync_q & ~fclk_prev_q;

        tick_cnt_d  = tick_cnt_q;
        state_d     = state_q;
        frame_d     = frame_q;
        frame_adv_d = 1'b0;
        loop_next   = ST_STAND;
        step        = 1'b0;

        // A pulse that arrives on the step cycle itself takes part in that step
        atk_eff     = pend_atk_q | attack;
        hit_eff     = pend_hit_q | (hit & ~hit_ignore);
        pend_atk_d  = atk_eff;
        pend_hit_d  = hit_eff;

`ifdef HURT_IFRAME_EN
        iframe_cnt_d = iframe_cnt_q;
        if (tick_q && (iframe_cnt_q != '0))
            iframe_cnt_d = iframe_cnt_q - 1'b1;
`endif

        if (tick_q) begin
            if (tick_cnt_q == 4'(TICKS_PER_FRAME - 1)) begin
                step       = 1'b1;
                tick_cnt_d = 4'd0;
            end else begin
                tick_cnt_d = tick_cnt_q + 4'd1;
            end
        end

        if (step) begin
            frame_adv_d = 1'b1;
            if (hit_eff) begin
                // A hit wins over everything and also cancels a queued attack
                state_d    = ST_HURT;
                frame_d    = 8'd0;
                pend_hit_d = 1'b0;
                pend_atk_d = 1'b0;
            end else if (state_q == ST_HURT || state_q == ST_ATTACK) begin
                if (frame_q == last_frame(state_q)) begin
                    state_d = ST_STAND;
                    frame_d = 8'd0;
                    // Attacks pressed during an attack are dropped, not chained
                    if (state_q == ST_ATTACK)
                        pend_atk_d = 1'b0;
`ifdef HURT_IFRAME_EN
                    if (state_q == ST_HURT)
                        iframe_cnt_d = IFW'(IFRAME_TICKS);
`endif
                end else begin
                    frame_d = frame_q + 8'd1;
                end
            end else if (atk_eff) begin
                state_d    = ST_ATTACK;
                frame_d    = 8'd0;
                pend_atk_d = 1'b0;
            end else begin
                if (defend)
                    loop_next = ST_DEFEND;
                else if (move_l ^ move_r)
                    loop_next = move_l ? ST_MOVE_L : ST_MOVE_R;
                else
                    loop_next = ST_STAND;

                state_d = loop_next;
                if (loop_next != state_q)
                    frame_d = 8'd0;
                else if (loop_next == ST_DEFEND)
                    frame_d = (frame_q >= last_frame(ST_DEFEND)) ? last_frame(ST_DEFEND)
                                                                 : frame_q + 8'd1;
                else
                    frame_d = (frame_q == last_frame(loop_next)) ? 8'd0 : frame_q + 8'd1;
            end
        end
    end

    // State register; reset takes effect immediately
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fclk_meta_q <= 1'b0;
            fclk_sync_q <= 1'b0;
            fclk_prev_q <= 1'b0;
            tick_q      <= 1'b0;
            tick_cnt_q  <= 4'd0;
            pend_atk_q  <= 1'b0;
            pend_hit_q  <= 1'b0;
            state_q     <= ST_STAND;
            frame_q     <= 8'd0;
            frame_adv_q <= 1'b0;
`ifdef HURT_IFRAME_EN
            iframe_cnt_q <= '0;
`endif
        end else begin
            fclk_meta_q <= fclk_meta_d;
            fclk_sync_q <= fclk_sync_d;
            fclk_prev_q <= fclk_prev_d;
            tick_q      <= tick_d;
            tick_cnt_q  <= tick_cnt_d;
            pend_atk_q  <= pend_atk_d;
            pend_hit_q  <= pend_hit_d;
            state_q     <= state_d;
            frame_q     <= frame_d;
            frame_adv_q <= frame_adv_d;
`ifdef HURT_IFRAME_EN
            iframe_cnt_q <= iframe_cnt_d;
`endif
        end
    end

    assign char_state = {5'd0, state_q};
    assign frame_num  = frame_q;
    assign frame_adv  = frame_adv_q;
    assign hit_window = (state_q == ST_ATTACK) && (frame_q == 8'(ATTACK_HIT_FRAME));
    assign busy       = (state_q == ST_ATTACK) || (state_q == ST_HURT);

endmodule

// File: tb/tb_fighter_anim_sequencer.sv
// Directed bench for fighter_anim_sequencer with its default parameters
// (4 ticks per step, strips 8/5/9/4/1 frames, hit frame 4).
module tb_fighter_anim_sequencer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_clk = 1'b0;
    logic       move_l = 1'b0;
    logic       move_r = 1'b0;
    logic       defend = 1'b0;
    logic       attack = 1'b0;
    logic       hit = 1'b0;
    logic [7:0] char_state;
    logic [7:0] frame_num;
    logic       frame_adv;
    logic       hit_window;
    logic       busy;

    int vec_cnt = 0;
    int err_cnt = 0;
    int adv_cnt = 0;

    fighter_anim_sequencer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .move_l     (move_l),
        .move_r     (move_r),
        .defend     (defend),
        .attack     (attack),
        .hit        (hit),
        .char_state (char_state),
        .frame_num  (frame_num),
        .frame_adv  (frame_adv),
        .hit_window (hit_window),
        .busy       (busy)
    );

    always #5 Clk = ~Clk;

    // Count frame_adv pulses; each step window should contain exactly one
    always @(negedge Clk) if (frame_adv) adv_cnt = adv_cnt + 1;

    task automatic tick_once();
        @(negedge Clk) frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic step_once();
        adv_cnt = 0;
        repeat (4) tick_once();
    endtask

    task automatic pulse(input logic a, input logic h);
        @(negedge Clk);
        attack = a;
        hit    = h;
        @(negedge Clk);
        attack = 1'b0;
        hit    = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge Clk) Reset = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_reset();
        #1;
        vec_cnt++;
        if (char_state !== 8'd0 || frame_num !== 8'd0 || frame_adv !== 1'b0 ||
            hit_window !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_in: got st=%0d fr=%0d adv=%b hw=%b busy=%b want 0/0/0/0/0",
                     char_state, frame_num, frame_adv, hit_window, busy);
        end
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        repeat (4) @(negedge Clk);
        vec_cnt++;
        if (char_state !== 8'd0 || frame_num !== 8'd0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_out: got st=%0d fr=%0d busy=%b want 0/0/0",
                     char_state, frame_num, busy);
        end
    endtask

    task automatic test_stand_loop();
        adv_cnt = 0;
        repeat (2) tick_once();
        vec_cnt++;
        if (frame_num !== 8'd0 || adv_cnt != 0) begin
            err_cnt++;
            $display("FAIL stand_midstep: got fr=%0d adv=%0d want 0/0", frame_num, adv_cnt);
        end
        repeat (2) tick_once();
        vec_cnt++;
        if (char_state !== 8'd0 || frame_num !== 8'd1 || adv_cnt != 1) begin
            err_cnt++;
            $display("FAIL stand_step1: got st=%0d fr=%0d adv=%0d want 0/1/1",
                     char_state, frame_num, adv_cnt);
        end
        for (int i = 2; i <= 8; i++) begin
            step_once();
            vec_cnt++;
            if (char_state !== 8'd0 || frame_num !== 8'(i % 8) || adv_cnt != 1) begin
                err_cnt++;
                $display("FAIL stand_loop%0d: got st=%0d fr=%0d adv=%0d want 0/%0d/1",
                         i, char_state, frame_num, adv_cnt, i % 8);
            end
        end
    endtask

    task automatic test_attack();
        pulse(1'b1, 1'b0);
        for (int f = 0; f <= 8; f++) begin
            step_once();
            vec_cnt++;
            if (char_state !== 8'd1 || frame_num !== 8'(f) || busy !== 1'b1 ||
                hit_window !== (f == 4) || adv_cnt != 1) begin
                err_cnt++;
                $display("FAIL attack_f%0d: got st=%0d fr=%0d busy=%b hw=%b adv=%0d want 1/%0d/1/%b/1",
                         f, char_state, frame_num, busy, hit_window, adv_cnt, f, (f == 4));
            end
        end
        step_once();
        vec_cnt++;
        if (char_state !== 8'd0 || frame_num !== 8'd0 || busy !== 1'b0 || hit_window !== 1'b0) begin
            err_cnt++;
            $display("FAIL attack_end: got st=%0d fr=%0d busy=%b hw=%b want 0/0/0/0",
                     char_state, frame_num, busy, hit_window);
        end
    endtask

    task automatic test_attack_hit_same();
        pulse(1'b1, 1'b1);
        for (int f = 0; f <= 3; f++) begin
            step_once();
            vec_cnt++;
            if (char_state !== 8'd4 || frame_num !== 8'(f) || busy !== 1'b1) begin
                err_cnt++;
                $display("FAIL hurt_f%0d: got st=%0d fr=%0d busy=%b want 4/%0d/1",
                         f, char_state, frame_num, busy, f);
            end
        end
        step_once();
        vec_cnt++;
        if (char_state !== 8'd0 || frame_num !== 8'd0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL hurt_end: got st=%0d fr=%0d busy=%b want 0/0/0",
                     char_state, frame_num, busy);
        end
        step_once();
        vec_cnt++;
        if (char_state !== 8'd0 || frame_num !== 8'd1) begin
            err_cnt++;
            $display("FAIL no_queued_attack: got st=%0d fr=%0d want 0/1", char_state, frame_num);
        end
    endtask

    task automatic test_moves();
        move_l = 1'b1;
        move_r = 1'b1;
        step_once();
        vec_cnt++;
        if (char_state !== 8'd0 || frame_num !== 8'd2) begin
            err_cnt++;
            $display("FAIL both_moves: got st=%0d fr=%0d want 0/2", char_state, frame_num);
        end
        move_l = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            step_once();
            vec_cnt++;
            if (char_state !== 8'd3 || frame_num !== 8'(i % 5) || busy !== 1'b0) begin
                err_cnt++;
                $display("FAIL move_r%0d: got st=%0d fr=%0d busy=%b want 3/%0d/0",
                         i, char_state, frame_num, busy, i % 5);
            end
        end
        defend = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step_once();
            vec_cnt++;
            if (char_state !== 8'd5 || frame_num !== 8'd0 || busy !== 1'b0) begin
                err_cnt++;
                $display("FAIL defend%0d: got st=%0d fr=%0d busy=%b want 5/0/0",
                         i, char_state, frame_num, busy);
            end
        end
        defend = 1'b0;
        move_r = 1'b0;
        move_l = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step_once();
            vec_cnt++;
            if (char_state !== 8'd2 || frame_num !== 8'(i)) begin
                err_cnt++;
                $display("FAIL move_l%0d: got st=%0d fr=%0d want 2/%0d", i, char_state, frame_num, i);
            end
        end
        move_l = 1'b0;
        step_once();
        vec_cnt++;
        if (char_state !== 8'd0 || frame_num !== 8'd0) begin
            err_cnt++;
            $display("FAIL back_to_stand: got st=%0d fr=%0d want 0/0", char_state, frame_num);
        end
    endtask

    task automatic test_hurt_restart();
        pulse(1'b0, 1'b1);
        for (int f = 0; f <= 2; f++) begin
            step_once();
            vec_cnt++;
            if (char_state !== 8'd4 || frame_num !== 8'(f)) begin
                err_cnt++;
                $display("FAIL hurt2_f%0d: got st=%0d fr=%0d want 4/%0d", f, char_state, frame_num, f);
            end
        end
        pulse(1'b0, 1'b1);
        step_once();
        vec_cnt++;
`ifdef HURT_IFRAME_EN
        if (char_state !== 8'd4 || frame_num !== 8'd3) begin
            err_cnt++;
            $display("FAIL hurt_iframe: got st=%0d fr=%0d want 4/3", char_state, frame_num);
        end
        step_once();
        pulse(1'b0, 1'b1);
        step_once();
        vec_cnt++;
        if (char_state !== 8'd0 || frame_num !== 8'd1) begin
            err_cnt++;
            $display("FAIL iframe_ignore: got st=%0d fr=%0d want 0/1", char_state, frame_num);
        end
`else
        if (char_state !== 8'd4 || frame_num !== 8'd0) begin
            err_cnt++;
            $display("FAIL hurt_restart: got st=%0d fr=%0d want 4/0", char_state, frame_num);
        end
`endif
    endtask

    task automatic test_reset_mid_attack();
        apply_reset();
        pulse(1'b1, 1'b0);
        repeat (7) step_once();
        vec_cnt++;
        if (char_state !== 8'd1 || frame_num !== 8'd6 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL pre_reset: got st=%0d fr=%0d busy=%b want 1/6/1", char_state, frame_num, busy);
        end
        @(negedge Clk) Reset = 1'b0;
        #1;
        vec_cnt++;
        if (char_state !== 8'd0 || frame_num !== 8'd0 || busy !== 1'b0 || hit_window !== 1'b0) begin
            err_cnt++;
            $display("FAIL async_reset: got st=%0d fr=%0d busy=%b hw=%b want 0/0/0/0",
                     char_state, frame_num, busy, hit_window);
        end
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        adv_cnt = 0;
        repeat (3) tick_once();
        vec_cnt++;
        if (char_state !== 8'd0 || frame_num !== 8'd0 || adv_cnt != 0) begin
            err_cnt++;
            $display("FAIL post_reset_hold: got st=%0d fr=%0d adv=%0d want 0/0/0",
                     char_state, frame_num, adv_cnt);
        end
        tick_once();
        vec_cnt++;
        if (char_state !== 8'd0 || frame_num !== 8'd1 || adv_cnt != 1) begin
            err_cnt++;
            $display("FAIL post_reset_step: got st=%0d fr=%0d adv=%0d want 0/1/1",
                     char_state, frame_num, adv_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_stand_loop();
        test_attack();
        test_attack_hit_same();
        test_moves();
        test_hurt_restart();
        test_reset_mid_attack();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
